mod12_count_checker: RTL and testbench

MOD12_COUNT_CHECKER -- requirements
Module: mod12_count_checker

---
 rtl/counter_pkg.sv | 32 +++
 rtl/mod12_count_checker.sv | 127 ++++++++++++
 tb/tb_mod12_count_checker.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants, FSM state type and next-count rule for the mod-12 counter
// and the checker that watches it.
package counter_pkg;

    localparam int MOD12 = 12;
    localparam int MAX   = MOD12 - 1;
    localparam int CNT_W = 4;

    typedef enum logic {
        UNSYNC = 1'b0,
        TRACK  = 1'b1
    } chk_state_e;

    // Value the counter must present one edge after (cur, load, data) was sampled.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cur,
        input logic             load,
        input logic [CNT_W-1:0] data,
        input logic [CNT_W-1:0] last
    );
        logic [CNT_W-1:0] nxt;
        if (load) begin
            nxt = data;
        end else if (cur == last) begin
            nxt = {CNT_W{1'b0}};
        end else begin
            nxt = cur + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mod12_count_checker.sv
// Watches a loadable mod-MOD counter and flags sequence errors, illegal loads
// and counts verified wrap-arounds.
import counter_pkg::*;

module mod12_count_checker #(
    parameter int MOD   = MOD12,
    parameter int WRAPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [3:0]       data,
    input  logic [3:0]       count,
    input  logic             clr,
    output logic             in_sync,
    output logic             err,
    output logic             err_sticky,
    output logic             bad_load,
    output logic [WRAPW-1:0] wrap_cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);
    localparam logic [WRAPW-1:0] WRAP_ONE = {{(WRAPW-1){1'b0}}, 1'b1};
    localparam logic [WRAPW-1:0] WRAP_SAT = {WRAPW{1'b1}};

    chk_state_e       state_q, state_d, fsm_next;
    logic [CNT_W-1:0] prev_count_q, prev_count_d;
    logic             prev_load_q, prev_load_d;
    logic [CNT_W-1:0] prev_data_q, prev_data_d;
    logic             err_q, err_d;
    logic             bad_load_q, bad_load_d;
    logic             err_sticky_q, err_sticky_d;
    logic [WRAPW-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [CNT_W-1:0] expected_cnt;
    logic             count_legal;
    logic             wrap_hit;

    // Next-state, compare, sticky and wrap-counter logic.
    always_comb begin
        fsm_next     = state_q;
        err_d        = 1'b0;
        wrap_hit     = 1'b0;
        err_sticky_d = err_sticky_q;
        wrap_cnt_d   = wrap_cnt_q;

        expected_cnt = next_count(prev_count_q, prev_load_q, prev_data_q, LAST);
        count_legal  = (count <= LAST);
        bad_load_d   = load && (data > LAST);

        // data is don't-care without load, so keep X out of the history.
        prev_count_d = count;
        prev_load_d  = load;
        prev_data_d  = load ? data : {CNT_W{1'b0}};

        case (state_q)
            UNSYNC: begin
                if (count_legal) begin
                    fsm_next = TRACK;
                end else begin
                    fsm_next = UNSYNC;
                end
            end
            TRACK: begin
                if (!count_legal || (count != expected_cnt)) begin
                    err_d    = 1'b1;
                    fsm_next = UNSYNC;
                end else begin
                    fsm_next = TRACK;
                    wrap_hit = !prev_load_q && (prev_count_q == LAST)
                               && (count == {CNT_W{1'b0}});
                end
            end
            default: begin
                fsm_next = UNSYNC;
            end
        endcase

        // An illegal load leaves nothing meaningful to compare on the next edge.
        state_d = bad_load_d ? UNSYNC : fsm_next;

        if (err_d || bad_load_d) begin
            err_sticky_d = 1'b1;
        end else if (clr) begin
            err_sticky_d = 1'b0;
        end else begin
            err_sticky_d = err_sticky_q;
        end

        if (clr) begin
            wrap_cnt_d = {WRAPW{1'b0}};
        end else if (wrap_hit && (wrap_cnt_q != WRAP_SAT)) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
        end else begin
            wrap_cnt_d = wrap_cnt_q;
        end
    end

    // State and history registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= UNSYNC;
            prev_count_q <= {CNT_W{1'b0}};
            prev_load_q  <= 1'b0;
            prev_data_q  <= {CNT_W{1'b0}};
            err_q        <= 1'b0;
            bad_load_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            wrap_cnt_q   <= {WRAPW{1'b0}};
        end else begin
            state_q      <= state_d;
            prev_count_q <= prev_count_d;
            prev_load_q  <= prev_load_d;
            prev_data_q  <= prev_data_d;
            err_q        <= err_d;
            bad_load_q   <= bad_load_d;
            err_sticky_q <= err_sticky_d;
            wrap_cnt_q   <= wrap_cnt_d;
        end
    end

    assign in_sync    = (state_q == TRACK);
    assign err        = err_q;
    assign bad_load   = bad_load_q;
    assign err_sticky = err_sticky_q;
    assign wrap_cnt   = wrap_cnt_q;

endmodule

// File: tb/tb_mod12_count_checker.sv
// Self-checking bench for mod12_count_checker: directed scenarios plus random
// traffic compared against a behavioural model of the checking rules.
module tb_mod12_count_checker;

    localparam int MODV  = 12;
    localparam int WRAPW = 8;
    localparam int WMAX  = (1 << WRAPW) - 1;

    logic             clk = 1'b0;
    logic             rst, load, clr;
    logic [3:0]       data, count;
    logic             in_sync, err, err_sticky, bad_load;
    logic [WRAPW-1:0] wrap_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: what the outputs must read after each edge.
    bit m_sync, m_err, m_bl, m_sticky;
    int m_wrap;
    int m_pc, m_pd;
    bit m_pl;
    int cnt_true;

    always #5 clk = ~clk;

    mod12_count_checker #(.MOD(MODV), .WRAPW(WRAPW)) dut (
        .clk(clk), .rst(rst), .load(load), .data(data), .count(count), .clr(clr),
        .in_sync(in_sync), .err(err), .err_sticky(err_sticky),
        .bad_load(bad_load), .wrap_cnt(wrap_cnt)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_edge(input bit r, input bit c, input int cv, input bit ld, input int dv);
        bit legal, bl, e, inc, nsync;
        int exp_v;
        if (r) begin
            m_sync = 0; m_err = 0; m_bl = 0; m_sticky = 0; m_wrap = 0;
            m_pc = 0; m_pl = 0; m_pd = 0;
        end else begin
            legal = (cv < MODV);
            bl    = ld && (dv >= MODV);
            e     = 0;
            inc   = 0;
            if (m_sync) begin
                exp_v = m_pl ? m_pd : (m_pc + 1) % MODV;
                e     = !legal || (cv != exp_v);
                inc   = !e && !m_pl && (m_pc == MODV - 1) && (cv == 0);
                nsync = !e;
            end else begin
                nsync = legal;
            end
            if (bl) nsync = 0;
            m_sync = nsync;
            m_err  = e;
            m_bl   = bl;
            if (e || bl) m_sticky = 1;
            else if (c) m_sticky = 0;
            if (c) m_wrap = 0;
            else if (inc && m_wrap < WMAX) m_wrap = m_wrap + 1;
            m_pc = cv;
            m_pl = ld;
            m_pd = ld ? dv : 0;
        end
    endtask

    task automatic tick(input bit r, input bit c, input bit ld, input int dv, input int cv);
        rst = r; clr = c; load = ld; data = dv[3:0]; count = cv[3:0];
        @(posedge clk);
        #1;
        model_edge(r, c, cv, ld, dv);
        if (r) cnt_true = 0;
        else if (ld) cnt_true = dv;
        else cnt_true = (cv >= MODV - 1) ? 0 : cv + 1;
        chk("in_sync", in_sync, m_sync);
        chk("err", err, m_err);
        chk("bad_load", bad_load, m_bl);
        chk("err_sticky", err_sticky, m_sticky);
        chk("wrap_cnt", wrap_cnt, m_wrap);
    endtask

    task automatic run_free(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, $urandom_range(0, 15), cnt_true);
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 16 && cnt_true != target; i++) run_free(1);
        chk("reach_target", cnt_true, target);
    endtask

    initial begin
        bit r, c, ld;
        int dv, cv;
        rst = 1'b1; clr = 1'b0; load = 1'b0; data = 4'd0; count = 4'd0;
        cnt_true = 0;

        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chk("rst_in_sync", in_sync, 0);
        chk("rst_wrap", wrap_cnt, 0);
        chk("rst_sticky", err_sticky, 0);

        // Free-running counter from 0: two verified wraps in 30 samples.
        run_free(30);
        chk("free_wrap2", wrap_cnt, 2);
        chk("free_sticky", err_sticky, 0);
        chk("free_sync", in_sync, 1);

        // Load 5 while at 9, then 5,6,7 must be accepted.
        run_until(9);
        tick(0, 0, 1, 5, 9);
        run_free(3);
        chk("load_err", err, 0);
        chk("load_sticky", err_sticky, 0);
        chk("load_cnt", cnt_true, 8);

        // 3 where 8 is expected.
        run_until(8);
        tick(0, 0, 0, 0, 3);
        chk("glitch_err", err, 1);
        chk("glitch_sync", in_sync, 0);
        chk("glitch_sticky", err_sticky, 1);
        run_free(1);
        chk("resync_err", err, 0);
        chk("resync_sync", in_sync, 1);

        // Illegal load 13, then clr while the illegal count is sampled.
        tick(0, 0, 1, 13, cnt_true);
        chk("badld_pulse", bad_load, 1);
        chk("badld_err", err, 0);
        chk("badld_sticky", err_sticky, 1);
        tick(0, 1, 0, 0, cnt_true);
        chk("clr_sticky", err_sticky, 0);
        chk("clr_wrap", wrap_cnt, 0);
        chk("skip13_err", err, 0);
        run_free(2);

        // clr against a same-edge illegal load: the set wins.
        tick(0, 1, 1, 14, cnt_true);
        chk("clr_vs_set", err_sticky, 1);
        run_free(3);

        // Reset while the counter shows 11, then resync on 0.
        run_until(11);
        tick(1, 0, 0, 0, 11);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_wrap", wrap_cnt, 0);
        run_free(1);
        chk("post_rst_err", err, 0);
        chk("post_rst_sync", in_sync, 1);

        // 300+ wraps saturate the wrap counter.
        run_free(301 * MODV);
        chk("wrap_sat", wrap_cnt, WMAX);
        run_free(2 * MODV);
        chk("wrap_hold", wrap_cnt, WMAX);

        // Random traffic: loads, illegal loads, glitches, clr and reset.
        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom % 100) == 0;
            c  = ($urandom % 20) == 0;
            ld = ($urandom % 8) == 0;
            dv = $urandom_range(0, 15);
            cv = (($urandom % 32) == 0) ? $urandom_range(0, 15) : cnt_true;
            tick(r, c, ld, dv, cv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
